xor_stream_descrambler: RTL and testbench
=========================================

// Module: xor_stream_descrambler
// PURPOSE
//  Receive-side additive descrambler for N-bit data words scrambled by XOR with a PRBS31 keystream.
//  XORs each accepted word with a locally generated keystream word to recover plaintext.
//  Sits after the link receiver and before word consumers.
//  Uses valid/ready handshakes on both sides with one registered output stage.
// PARAMETERS
//  N        32   data word width; keystream advances N LFSR steps per word (N >= 1)
//  CNT_W    16   width of the accepted-word counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  seed_load  in   1      pulse: load seed into LFSR, enter RUN
//  seed       in   31     LFSR seed; 31'h0 is replaced by 31'h1
//  in_valid   in   1      scrambled word available
//  in_ready   out  1      block can accept a word this cycle
//  in_data    in   N      scrambled word
//  out_valid  out  1      descrambled word held in output register
//  out_ready  in   1      consumer accepts output this cycle
//  out_data   out  N      descrambled word
//  word_cnt   out  CNT_W  words accepted since last seed_load; wraps to 0
//  locked     out  1      1 in RUN state
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, lfsr=31'h1, out_valid=0, out_data=0, word_cnt=0, locked=0.
//  - LFSR s[30:0], one step: b = s[30]^s[27]; s <= {s[29:0], b}.
//  - Keystream word k: k[N-1-j] = b of step j, j=0..N-1 (MSB first, from current state).
//    After each accepted word, lfsr <= state after N steps. Combinational unrolled next-state.
//  - States:
//    IDLE: in_ready=0. seed_load -> RUN.
//    RUN:  in_ready = ~seed_load & (~out_valid | out_ready).
//          seed_load while in RUN reseeds and stays in RUN.
//  - seed_load (any state):
//    lfsr <= (seed==0) ? 31'h1 : seed; word_cnt <= 0.
//    No input is accepted that cycle.
//    out_valid/out_data are untouched; a pending output still drains normally.
//  - Accept (in_valid & in_ready):
//    next cycle out_data = in_data ^ k, out_valid=1.
//    lfsr advances N steps; word_cnt += 1 (mod 2^CNT_W).
//    Latency is 1 cycle. Full throughput (1 word/clk) when out_ready is held 1.
//  - Output:
//    out_valid clears after out_valid & out_ready with no new accept.
//    Simultaneous drain and accept: register reloads, out_valid stays 1.
//    out_data is stable while out_valid & ~out_ready.
//  - in_valid with in_ready=0: no state change; the word is not consumed.
//  - Reset asserted mid-stream: all state returns to reset values immediately (async).
//    The block requires a new seed_load before it accepts data again.
// TESTING
//  1 Reset, then seed_load with seed=31'h1, then word 32'h00000012.
//    -> out_data=32'h00000000 one cycle later; word_cnt=1.
//  2 seed=31'h0, then word 32'hFFFFFFFF.
//    -> seed treated as 31'h1; out_data=32'hFFFFFFED.
//  3 Send 1000 random words scrambled by a bench PRBS31 scrambler (same seed), out_ready=1.
//    -> output matches plaintext word-for-word; in_ready stays 1; word_cnt=1000.
//  4 Hold out_ready=0 while sending 2 words.
//    -> first word held stable; in_ready=0; second word not consumed.
//    -> after out_ready=1, both words delivered in order with no loss.
//  5 In IDLE, drive in_valid=1.
//    -> in_ready=0; no output; locked=0.
//    Mid-stream seed_load -> word_cnt=0; next word uses the fresh keystream.
//  6 Pulse rst_n low mid-stream with out_valid=1.
//    -> out_valid=0, locked=0, word_cnt=0 immediately (no clock edge needed).
//  7 With CNT_W=4, accept 17 words -> word_cnt=1.

Source files
------------

// File: rtl/xor_stream_descrambler.sv
// Additive PRBS31 descrambler: XORs each accepted word with an N-bit keystream word
// and presents the result through a single registered valid/ready output stage.
module xor_stream_descrambler #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [30:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic             locked
);

    localparam logic [30:0] LFSR_ONE = 31'h1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [30:0]    lfsr;
    logic [30:0]    lfsr_next;
    logic [N-1:0]   key;
    logic           accept;

    // Unrolls N LFSR steps; keystream bits are collected MSB first.
    function automatic logic [N+30:0] prbs_advance(input logic [30:0] s_in);
        logic [30:0]  s;
        logic [N-1:0] k;
        logic         b;
        s = s_in;
        k = '0;
        for (int j = 0; j < N; j++) begin
            b           = s[30] ^ s[27];
            k[N-1-j]    = b;
            s           = {s[29:0], b};
        end
        return {k, s};
    endfunction

    always_comb begin
        {key, lfsr_next} = prbs_advance(lfsr);
    end

    assign in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign locked   = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= LFSR_ONE;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // An all-zero seed would lock the LFSR, so it is forced to 1.
            if (seed_load) begin
                state    <= RUN;
                lfsr     <= (seed == 31'h0) ? LFSR_ONE : seed;
                word_cnt <= '0;
            end else if (accept) begin
                lfsr     <= lfsr_next;
                word_cnt <= word_cnt + CNT_W'(1);
            end

            if (accept) begin
                out_data  <= in_data ^ key;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench for xor_stream_descrambler: fixed vectors plus a bit-serial PRBS31 scrambler model.
module tb_xor_stream_descrambler;

    logic        clk;
    logic        rst_n;
    logic        seed_load;
    logic [30:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] word_cnt;
    logic        locked;

    logic        seed_load2;
    logic        in_valid2;
    logic        in_ready2;
    logic [31:0] in_data2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [3:0]  word_cnt2;
    logic        locked2;

    int checks = 0;
    int errors = 0;

    logic [30:0] mstate;

    xor_stream_descrambler #(.N(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .word_cnt(word_cnt), .locked(locked)
    );

    xor_stream_descrambler #(.N(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load2), .seed(31'h1),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
        .word_cnt(word_cnt2), .locked(locked2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_seed(input logic [30:0] s);
        mstate = (s == 31'h0) ? 31'h1 : s;
    endtask

    // Bit-serial keystream: one LFSR step per bit, shifted in MSB first.
    task automatic model_key(output logic [31:0] k);
        logic b;
        k = '0;
        for (int j = 0; j < 32; j++) begin
            b      = mstate[30] ^ mstate[27];
            mstate = {mstate[29:0], b};
            k      = {k[30:0], b};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] k;
        logic [31:0] plain;
        logic [31:0] wa, wb, wc;
        logic        rdy_ok;
        logic        data_ok;

        rst_n = 1'b0; seed_load = 1'b0; seed = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        seed_load2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: seed 1, word 0x12 -> 0
        seed_load = 1'b1; seed = 31'h1;
        tick();
        seed_load = 1'b0;
        chk("t1_locked", 64'(locked), 64'd1);
        chk("t1_cnt_after_seed", 64'(word_cnt), 64'd0);
        in_valid = 1'b1; in_data = 32'h0000_0012;
        #1 chk("t1_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'h0000_0000);
        chk("t1_word_cnt", 64'(word_cnt), 64'd1);

        // Test 2: zero seed behaves as seed 1
        seed_load = 1'b1; seed = 31'h0;
        tick();
        seed_load = 1'b0;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        chk("t2_out_data", 64'(out_data), 64'hFFFF_FFED);
        chk("t2_word_cnt", 64'(word_cnt), 64'd1);
        tick();

        // Test 3: 1000 words scrambled by the bench model
        seed_load = 1'b1; seed = 31'h5A5A_1234;
        model_seed(31'h5A5A_1234);
        tick();
        seed_load = 1'b0;
        rdy_ok = 1'b1; data_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            plain = $urandom;
            model_key(k);
            in_valid = 1'b1; in_data = plain ^ k;
            #1 if (in_ready !== 1'b1) rdy_ok = 1'b0;
            tick();
            if (out_valid !== 1'b1 || out_data !== plain) begin
                if (data_ok) chk("t3_first_bad_word", 64'(out_data), 64'(plain));
                data_ok = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("t3_all_words", 64'(data_ok), 64'd1);
        chk("t3_in_ready_held", 64'(rdy_ok), 64'd1);
        chk("t3_word_cnt", 64'(word_cnt), 64'd1000);
        tick();
        chk("t3_drained", 64'(out_valid), 64'd0);

        // Test 4: backpressure with two words
        wa = 32'hCAFE_0001; wb = 32'hBEEF_0002;
        out_ready = 1'b0;
        model_key(k);
        in_valid = 1'b1; in_data = wa ^ k;
        tick();
        model_key(k);
        in_data = wb ^ k;
        chk("t4_a_held", 64'(out_data), 64'(wa));
        #1 chk("t4_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        chk("t4_a_stable", 64'(out_data), 64'(wa));
        chk("t4_valid_held", 64'(out_valid), 64'd1);
        chk("t4_b_not_taken", 64'(word_cnt), 64'd1001);
        tick();
        chk("t4_a_stable2", 64'(out_data), 64'(wa));
        out_ready = 1'b1;
        #1 chk("t4_in_ready_back", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_b_out", 64'(out_data), 64'(wb));
        chk("t4_b_valid", 64'(out_valid), 64'd1);
        chk("t4_cnt", 64'(word_cnt), 64'd1002);
        tick();
        chk("t4_drained", 64'(out_valid), 64'd0);

        // Test 5b: mid-stream reseed blocks input that cycle and restarts keystream
        seed_load = 1'b1; seed = 31'h0123_4567;
        in_valid = 1'b1; in_data = 32'h1111_1111;
        #1 chk("t5_seed_blocks", 64'(in_ready), 64'd0);
        tick();
        seed_load = 1'b0; in_valid = 1'b0;
        model_seed(31'h0123_4567);
        chk("t5_cnt_cleared", 64'(word_cnt), 64'd0);
        chk("t5_nothing_out", 64'(out_valid), 64'd0);
        wc = 32'h0BAD_F00D;
        model_key(k);
        in_valid = 1'b1; in_data = wc ^ k;
        tick();
        in_valid = 1'b0;
        chk("t5_fresh_key", 64'(out_data), 64'(wc));
        chk("t5_cnt_one", 64'(word_cnt), 64'd1);

        // Test 6: asynchronous reset with a pending output
        out_ready = 1'b0;
        tick();
        chk("t6_pending", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 64'(out_valid), 64'd0);
        chk("t6_locked_async", 64'(locked), 64'd0);
        chk("t6_cnt_async", 64'(word_cnt), 64'd0);
        chk("t6_data_async", 64'(out_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 5a: IDLE ignores input until seeded
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h0000_0012;
        #1 chk("t5_idle_ready", 64'(in_ready), 64'd0);
        chk("t5_idle_locked", 64'(locked), 64'd0);
        tick(); tick();
        chk("t5_idle_no_out", 64'(out_valid), 64'd0);
        chk("t5_idle_cnt", 64'(word_cnt), 64'd0);
        seed_load = 1'b1; seed = 31'h1;
        tick();
        seed_load = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t5_resume_data", 64'(out_data), 64'd0);
        chk("t5_resume_cnt", 64'(word_cnt), 64'd1);

        // Test 7: 4-bit counter wraps after 16 words
        seed_load2 = 1'b1;
        tick();
        seed_load2 = 1'b0;
        in_valid2 = 1'b1; in_data2 = 32'h0;
        #1 chk("t7_in_ready", 64'(in_ready2), 64'd1);
        tick();
        chk("t7_first_key", 64'(out_data2), 64'h0000_0012);
        chk("t7_locked", 64'(locked2), 64'd1);
        for (int i = 1; i < 16; i++) tick();
        chk("t7_wrap16", 64'(word_cnt2), 64'd0);
        tick();
        in_valid2 = 1'b0;
        chk("t7_cnt17", 64'(word_cnt2), 64'd1);
        chk("t7_valid", 64'(out_valid2), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
